// File: rtl/mfp_ahb_interconnect_pkg.sv
// Shared types and default address map for the parametrised AHB-Lite interconnect.
// Slots 4..7 of the default map never match (mask 0, base all-ones), so extra slaves stay dark.
package mfp_ahb_interconnect_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    ST_OKAY  = 2'd0,
    ST_SLAVE = 2'd1,
    ST_ERR1  = 2'd2,
    ST_ERR2  = 2'd3
  } ahb_state_e;

  localparam int MAX_SLAVES = 8;

  localparam logic [MAX_SLAVES*32-1:0] DEFAULT_ADDR_BASE = {
    {4{32'hffff_ffff}},
    32'h1f70_0000, 32'h1f80_0000, 32'h0000_0000, 32'h1fc0_0000
  };

  localparam logic [MAX_SLAVES*32-1:0] DEFAULT_ADDR_MASK = {
    {4{32'h0000_0000}},
    32'h1fff_0000, 32'h1fff_0000, 32'h1ffc_0000, 32'h1ffe_0000
  };

  function automatic logic is_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/mfp_ahb_interconnect_if.sv
// Bus bundle between the MIPS core, the interconnect and the slave ports.
interface mfp_ahb_interconnect_if #(
  parameter int N_SLAVES = 4
) ();
  logic [31:0]            HADDR;
  logic [1:0]             HTRANS;
  logic                   HWRITE;
  logic [31:0]            HRDATA;
  logic                   HREADY;
  logic                   HRESP;
  logic [N_SLAVES-1:0]    HSEL_S;
  logic [N_SLAVES*32-1:0] HRDATA_S;
  logic [N_SLAVES-1:0]    HREADYOUT_S;
  logic [N_SLAVES-1:0]    HRESP_S;

  // Interconnect view: address phase in, muxed response out.
  modport slave (
    input  HADDR, HTRANS, HWRITE, HRDATA_S, HREADYOUT_S, HRESP_S,
    output HRDATA, HREADY, HRESP, HSEL_S
  );

  modport master (
    output HADDR, HTRANS, HWRITE, HRDATA_S, HREADYOUT_S, HRESP_S,
    input  HRDATA, HREADY, HRESP, HSEL_S
  );
endinterface

// File: rtl/mfp_ahb_default_slave.sv
// Data-phase sequencer: tracks slave ownership, emits the two-cycle ERROR and
// forces an ERROR once a slave has stalled for TIMEOUT consecutive cycles.
module mfp_ahb_default_slave
  import mfp_ahb_interconnect_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hready_i,
  input  logic       nxt_valid_i,
  input  logic       nxt_err_i,
  input  logic       slv_ready_i,
  output ahb_state_e state_o,
  output logic       timeout_o
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  ahb_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;

  // The stall that would make the count reach TIMEOUT ends the slave data phase.
  assign timeout_o = (TIMEOUT > 0) && (state_q == ST_SLAVE) && !slv_ready_i
                     && (cnt_q == CNT_LAST);
  assign state_o   = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_OKAY;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_ERR1: begin
          state_q <= ST_ERR2;
          cnt_q   <= '0;
        end
        ST_OKAY, ST_SLAVE, ST_ERR2: begin
          if (hready_i) begin
            cnt_q <= '0;
            if (nxt_valid_i)    state_q <= ST_SLAVE;
            else if (nxt_err_i) state_q <= ST_ERR1;
            else                state_q <= ST_OKAY;
          end else if (timeout_o) begin
            state_q <= ST_ERR1;
            cnt_q   <= '0;
          end else if ((state_q == ST_SLAVE) && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end else begin
            cnt_q <= cnt_q;
          end
        end
        default: begin
          state_q <= ST_OKAY;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/mfp_ahb_interconnect.sv
// Single-master AHB-Lite interconnect: window decode, data-phase owner register
// and response mux, with unmapped/timeout errors delegated to the default slave.
module mfp_ahb_interconnect
  import mfp_ahb_interconnect_pkg::*;
#(
  parameter int                       N_SLAVES  = 4,
  parameter logic [N_SLAVES*32-1:0]   ADDR_BASE = DEFAULT_ADDR_BASE[N_SLAVES*32-1:0],
  parameter logic [N_SLAVES*32-1:0]   ADDR_MASK = DEFAULT_ADDR_MASK[N_SLAVES*32-1:0],
  parameter int                       TIMEOUT   = 255
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  mfp_ahb_interconnect_if.slave   bus
);

  localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

  logic                hit_any_s;
  logic [IDX_W-1:0]    hit_idx_s;
  logic [N_SLAVES-1:0] hsel_s;
  logic                nxt_valid_s;
  logic                nxt_err_s;
  logic                slv_ready_s;
  logic                timeout_s;
  logic                hready_s;
  logic                hresp_s;
  logic [31:0]         hrdata_s;
  ahb_state_e          state_s;

  logic                own_valid_q;
  logic                own_err_q;
  logic [IDX_W-1:0]    own_idx_q;

  // Downward scan so the lowest-index matching window wins.
  always_comb begin
    hit_any_s = 1'b0;
    hit_idx_s = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if ((bus.HADDR & ADDR_MASK[i*32 +: 32]) == ADDR_BASE[i*32 +: 32]) begin
        hit_any_s = 1'b1;
        hit_idx_s = IDX_W'(i);
      end
    end
    if (hit_any_s) hsel_s = N_SLAVES'(1) << hit_idx_s;
    else           hsel_s = '0;
  end

  assign nxt_valid_s = is_active(bus.HTRANS) && hit_any_s;
  assign nxt_err_s   = is_active(bus.HTRANS) && !hit_any_s;
  assign slv_ready_s = bus.HREADYOUT_S[own_idx_q];

  // A timed-out slave loses ownership so its late response can never reach the master.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      own_valid_q <= 1'b0;
      own_err_q   <= 1'b0;
      own_idx_q   <= '0;
    end else if (hready_s) begin
      own_valid_q <= nxt_valid_s;
      own_err_q   <= nxt_err_s;
      if (nxt_valid_s) own_idx_q <= hit_idx_s;
      else             own_idx_q <= own_idx_q;
    end else if (timeout_s) begin
      own_valid_q <= 1'b0;
      own_err_q   <= 1'b1;
    end else begin
      own_valid_q <= own_valid_q;
      own_err_q   <= own_err_q;
    end
  end

  mfp_ahb_default_slave #(.TIMEOUT(TIMEOUT)) u_default_slave (
    .clk         (HCLK),
    .rst_n       (HRESETn),
    .hready_i    (hready_s),
    .nxt_valid_i (nxt_valid_s),
    .nxt_err_i   (nxt_err_s),
    .slv_ready_i (slv_ready_s),
    .state_o     (state_s),
    .timeout_o   (timeout_s)
  );

  // Response mux back to the master.
  always_comb begin
    hready_s = 1'b1;
    hresp_s  = 1'b0;
    hrdata_s = 32'h0000_0000;
    case (state_s)
      ST_SLAVE: begin
        if (own_valid_q) begin
          hready_s = slv_ready_s;
          hresp_s  = bus.HRESP_S[own_idx_q];
          hrdata_s = bus.HRDATA_S[own_idx_q*32 +: 32];
        end else begin
          hready_s = 1'b1;
        end
      end
      ST_ERR1: begin
        hready_s = 1'b0;
        hresp_s  = own_err_q;
      end
      ST_ERR2: begin
        hready_s = 1'b1;
        hresp_s  = own_err_q;
      end
      ST_OKAY: hready_s = 1'b1;
      default: hready_s = 1'b1;
    endcase
  end

  assign bus.HSEL_S = hsel_s;
  assign bus.HREADY = hready_s;
  assign bus.HRESP  = hresp_s;
  assign bus.HRDATA = hrdata_s;

endmodule
